// File: rtl/tp_pkg.sv
// Shared constants for the tiny 8-bit processor:
// ALU op codes, instruction classes, 0x0-group sub-ops and FSM states.
package tp_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_MUL = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SHL = 4'd5;
   localparam logic [3:0] ALU_SHR = 4'd6;
   localparam logic [3:0] ALU_CRS = 4'd7;
   localparam logic [3:0] ALU_CLS = 4'd8;
   localparam logic [3:0] ALU_ASR = 4'd9;
   localparam logic [3:0] ALU_INC = 4'd10;
   localparam logic [3:0] ALU_DEC = 4'd11;

   localparam logic [3:0] CL_SYS = 4'h0;
   localparam logic [3:0] CL_ADD = 4'h1;
   localparam logic [3:0] CL_SUB = 4'h2;
   localparam logic [3:0] CL_MUL = 4'h3;
   localparam logic [3:0] CL_CMP = 4'h4;
   localparam logic [3:0] CL_AND = 4'h5;
   localparam logic [3:0] CL_XOR = 4'h6;
   localparam logic [3:0] CL_STR = 4'h7;
   localparam logic [3:0] CL_LDR = 4'h8;
   localparam logic [3:0] CL_JMP = 4'h9;
   localparam logic [3:0] CL_JC  = 4'hA;
   localparam logic [3:0] CL_JZ  = 4'hB;
   localparam logic [3:0] CL_LDI = 4'hC;
   localparam logic [3:0] CL_LDH = 4'hD;

   localparam logic [3:0] SOP_SHL = 4'h1;
   localparam logic [3:0] SOP_SHR = 4'h2;
   localparam logic [3:0] SOP_CRS = 4'h3;
   localparam logic [3:0] SOP_CLS = 4'h4;
   localparam logic [3:0] SOP_ASR = 4'h5;
   localparam logic [3:0] SOP_INC = 4'h6;
   localparam logic [3:0] SOP_DEC = 4'h7;
   localparam logic [3:0] SOP_HLT = 4'hF;

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

endpackage

// File: rtl/tp_regfile.sv
// 16x8 register file: async read, sync write,
// async active-low clear.
module tp_regfile #(
   parameter int NREG = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       we,
   input  logic [3:0] waddr,
   input  logic [7:0] wdata,
   input  logic [3:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem [NREG];

   assign rdata = mem[raddr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) mem[k] <= 8'h00;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/tp_exec_ctrl.sv
// Fetch/execute control of the tiny 8-bit processor:
// drives the external combinational ALU and holds state.
module tp_exec_ctrl
   import tp_pkg::*;
#(
   parameter int         NREG     = 16,
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] pc,
   output logic       instr_req,
   input  logic [7:0] instr,
   input  logic       instr_valid,
   output logic [3:0] alu_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_result,
   input  logic       alu_carry,
   input  logic [7:0] alu_ext,
   output logic [7:0] acc,
   output logic [7:0] ext,
   output logic       carry_flag,
   output logic       halted
);

   logic [1:0] state;
   logic [7:0] ir;
   logic [3:0] cls, idx;
   logic [3:0] op;
   logic       wr_acc, wr_c, wr_ext, wr_reg, take, hlt;
   logic [7:0] acc_nxt;
   logic       in_exec;

   assign cls       = ir[7:4];
   assign idx       = ir[3:0];
   assign in_exec   = (state == S_EXEC);
   assign instr_req = (state == S_FETCH);
   assign halted    = (state == S_HALT);
   assign alu_a     = acc;
   assign alu_op    = in_exec ? op : 4'd0;

   tp_regfile #(.NREG(NREG)) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (in_exec && wr_reg),
      .waddr (idx),
      .wdata (acc),
      .raddr (idx),
      .rdata (alu_b)
   );

   always_comb begin
      op      = 4'd0;
      acc_nxt = alu_result;
      wr_acc  = 1'b0;
      wr_c    = 1'b0;
      wr_ext  = 1'b0;
      wr_reg  = 1'b0;
      take    = 1'b0;
      hlt     = 1'b0;
      case (cls)
         CL_SYS: begin
            case (idx)
               SOP_SHL: begin op = ALU_SHL; wr_acc = 1'b1; end
               SOP_SHR: begin op = ALU_SHR; wr_acc = 1'b1; end
               SOP_CRS: begin op = ALU_CRS; wr_acc = 1'b1; end
               SOP_CLS: begin op = ALU_CLS; wr_acc = 1'b1; end
               SOP_ASR: begin op = ALU_ASR; wr_acc = 1'b1; end
               SOP_INC: begin
                  op = ALU_INC; wr_acc = 1'b1; wr_c = 1'b1;
               end
               SOP_DEC: begin
                  op = ALU_DEC; wr_acc = 1'b1; wr_c = 1'b1;
               end
               SOP_HLT: hlt = 1'b1;
               default: ;
            endcase
         end
         CL_ADD: begin op = ALU_ADD; wr_acc = 1'b1; wr_c = 1'b1; end
         CL_SUB: begin op = ALU_SUB; wr_acc = 1'b1; wr_c = 1'b1; end
         CL_MUL: begin op = ALU_MUL; wr_acc = 1'b1; wr_ext = 1'b1; end
         CL_CMP: begin op = ALU_SUB; wr_c = 1'b1; end
         CL_AND: begin op = ALU_AND; wr_acc = 1'b1; end
         CL_XOR: begin op = ALU_XOR; wr_acc = 1'b1; end
         CL_STR: wr_reg = 1'b1;
         CL_LDR: begin acc_nxt = alu_b; wr_acc = 1'b1; end
         CL_JMP: take = 1'b1;
         CL_JC:  take = carry_flag;
         CL_JZ:  take = (acc == 8'h00);
         CL_LDI: begin acc_nxt = {4'h0, idx}; wr_acc = 1'b1; end
         CL_LDH: begin acc_nxt = {idx, acc[3:0]}; wr_acc = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         ir         <= 8'h00;
         acc        <= 8'h00;
         ext        <= 8'h00;
         carry_flag <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (instr_valid) begin
                  ir    <= instr;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (wr_acc) acc <= acc_nxt;
               if (wr_c)   carry_flag <= alu_carry;
               if (wr_ext) ext <= alu_ext;
               // jump target is the register operand, evaluated on pre-instruction flags
               pc    <= take ? alu_b : pc + 8'd1;
               state <= hlt ? S_HALT : S_FETCH;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/tp_exec_ctrl.md
Name: tp_exec_ctrl

Overview:
- Execute/control stage of the tiny 8-bit processor, sitting directly upstream of the combinational ALU.
- Fetches an 8-bit instruction, decodes it and drives the ALU operand bus and op code.
- Captures the ALU result, carry and extended (multiply high-byte) outputs into the architectural state: accumulator, ext register, carry flag and a 16x8 register file.
- Owns the program counter and the fetch handshake.

Parameters:
- NREG, 16, number of general registers (index width = 4; other values unsupported).
- RESET_PC, 8'h00, program counter value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc  out  8  instruction address.
- instr_req  out  1  high while in FETCH.
- instr  in  8  instruction from instruction memory.
- instr_valid  in  1  instr is valid this cycle.
- alu_op  out  4  ALU operation code.
- alu_a  out  8  accumulator value to ALU.
- alu_b  out  8  register-file operand to ALU.
- alu_result  in  8  ALU low result.
- alu_carry  in  1  ALU carry/borrow.
- alu_ext  in  8  ALU multiply high byte.
- acc  out  8  accumulator.
- ext  out  8  extended register.
- carry_flag  out  1  carry flag.
- halted  out  1  core halted.

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - Reset clears pc (to RESET_PC), ir, acc, ext, carry_flag, halted and all registers to 0.
  - Reset forces state to FETCH. Reset takes effect immediately, including in the middle of an instruction.
- States: FETCH, EXEC, HALT.
  - FETCH: instr_req=1. If instr_valid, ir<=instr and go to EXEC; otherwise stay in FETCH with no state change.
  - EXEC: decode ir; write back on the clock edge; pc<=pc+1 (wraps 0xFF->0x00) or jump target; go to FETCH (HALT for HLT).
  - HALT: instr_req=0; all state frozen until reset.
- Throughput: 2 cycles per instruction with zero memory wait states.
- alu_a=acc at all times. alu_b=R[ir[3:0]] at all times.
- alu_op is the decoded op in EXEC and 0 otherwise.
- Encoding, class ir[7:4], operand i=ir[3:0]:
  - 0x0 group:
    - 00 NOP.
    - 01 SHL, 02 SHR, 03 CRS, 04 CLS, 05 ASR: acc<=result.
    - 06 INC, 07 DEC: acc<=result, carry<=alu_carry.
    - 0F HLT.
    - Other 0x0_ codes: NOP.
  - 1 ADD Ri, 2 SUB Ri: acc<=result, carry<=alu_carry.
  - 3 MUL Ri: acc<=result, ext<=alu_ext.
  - 4 CMP Ri: SUB op, carry<=alu_carry, acc unchanged.
  - 5 AND Ri, 6 XOR Ri: acc<=result.
  - 7 MOV Ri<-acc. 8 MOV acc<-Ri.
  - 9 JMP Ri: pc<=R[i].
  - A JC Ri: if carry_flag, pc<=R[i]; else pc+1.
  - B JZ Ri: if acc==0, pc<=R[i]; else pc+1.
  - C LDI: acc<={4'h0,i}. D LDH: acc[7:4]<=i.
  - E, F: NOP.
- carry_flag changes only on ADD/SUB/CMP/INC/DEC. ext changes only on MUL.
- Jump condition is evaluated on pre-instruction flag/acc values.
- A jump to the current pc is legal (self-loop).
- ALU op codes: ADD=0 SUB=1 MUL=2 AND=3 XOR=4 SHL=5 SHR=6 CRS=7 CLS=8 ASR=9 INC=10 DEC=11.
- The ALU is combinational; its result is sampled in the same EXEC cycle.

Decomposition:
- Package tp_pkg holds:
  - ALU op constants.
  - Instruction class and 0x0-group sub-op constants.
  - FSM state encoding.
- Sub-module tp_regfile: 16x8, one async read port, one synchronous write port, async active-low clear.

Test Plan:
- Reset mid-EXEC, rst_n low -> pc, acc, ext, carry_flag, halted = 0 within the same cycle; instr_req=1 after release.
- Program LDI 5; MOV R1; LDI 3; ADD R1 -> acc=0x08, carry_flag=0, pc=0x04 after 8 cycles.
- Program LDI 0; LDH 2; MOV R3; LDI F; LDH F; INC; JC R3 -> acc=0x00, carry_flag=1, pc=0x20.
- acc=0x10, R2=0x20, MUL R2 -> acc=0x00, ext=0x02, carry_flag unchanged.
- instr_valid held low for 3 cycles in FETCH -> pc stable, ir unchanged, no writes; proceeds on the first valid cycle.
- NOP at pc 0xFF -> pc wraps to 0x00.
- HLT -> halted=1, instr_req=0, pc frozen for 10+ cycles until reset.
